runtime_check_unit: RTL and testbench
=====================================

// Module: runtime_check_unit
// PURPOSE
//  Synthesizable, parametrised expectation checker placed beside risc_v_cpu.
//  Holds a table of expectations (register, PC or data-memory word) loaded before run.
//  Each entry is tagged either with an instruction address or as FINAL.
//  On every retired instruction it stalls retire, scans the table and compares
//  matching entries against live CPU state through a probe port; FINAL entries are scanned on request.
//  Generalises the fixed 3-checks-per-address bench: any number of checks per PC, bounded only by DEPTH.
// PARAMETERS
//  XLEN     32  data width of registers, memory words and expected values
//  ADDR_W   32  instruction address width
//  DEPTH    64  expectation table entries
//  IDX_W    6   register / memory-word index width
//  CNT_W    16  pass/fail counter width
// PORTS
//  clock          in   1       system clock
//  reset          in   1       synchronous, active-high
//  start          in   1       IDLE->RUN pulse
//  load_valid     in   1       table write request
//  load_ready     out  1       high in IDLE while count<DEPTH
//  load_final     in   1       entry is FINAL (load_pc ignored)
//  load_pc        in   ADDR_W  instruction address tag
//  load_kind      in   2       0 REG, 1 PC, 2 MEM, 3 reserved (rejected, not stored)
//  load_index     in   IDX_W   register / memory-word index
//  load_value     in   XLEN    expected value
//  retire_valid   in   1       CPU retired instr; state already committed
//  retire_ready   out  1       low while scanning (CPU stalls)
//  retire_pc      in   ADDR_W  address of retired instruction
//  retire_next_pc in   ADDR_W  PC after the instruction (kind PC compares to this)
//  final_req      in   1       level; request FINAL scan
//  probe_kind     out  2       selects state source
//  probe_index    out  IDX_W   register / word index
//  probe_data     in   XLEN    combinational state read, same cycle
//  pass_count     out  CNT_W   saturating
//  fail_count     out  CNT_W   saturating
//  fail_valid     out  1       one-cycle pulse per mismatch
//  fail_pc        out  ADDR_W  tag of failing entry (0 for FINAL)
//  fail_expected  out  XLEN    expected value of failing entry
//  fail_actual    out  XLEN    observed value of failing entry
//  done           out  1       FINAL scan complete; held until reset
// BEHAVIOUR
//  Reset: state IDLE, entry count 0, all counters/fail_* 0, retire_ready 0, done 0, probe_* 0.
//  States: IDLE -start-> RUN; RUN -retire accepted-> SCAN -last entry-> RUN;
//   RUN -final_req && !retire_valid-> FSCAN -last entry-> DONE (terminal).
//  Load: accepted on load_valid&&load_ready; entry appended at index count; count++.
//   load_ready=0 at count==DEPTH and outside IDLE; writes then are dropped.
//  retire_ready=1 only in RUN. Accept latches retire_pc/retire_next_pc, enters SCAN.
//  SCAN/FSCAN: one entry per cycle, index 0..count-1 in load order.
//   Match = valid && !final && tag==latched pc (SCAN), or final (FSCAN).
//   Compare in the same cycle probe_* is driven; PC kind compares latched next_pc, no probe.
//   Equal: pass_count++. Unequal: fail_count++, fail_valid pulse next cycle with fail_* registered.
//  Latency: retire accept to retire_ready high = count+1 cycles; count==0 gives 1 cycle.
//  Simultaneous retire_valid and final_req in RUN: retire wins; final_req must stay high.
//  start outside IDLE ignored; retire_valid outside RUN ignored (not acknowledged).
//  Counters saturate at all-ones, never wrap.
//  Reset mid-scan: aborts, clears table, no fail_valid pulse emitted afterwards.
// STRUCTURE
//  Package risc_v_check_pkg: check_kind_t {KIND_REG,KIND_PC,KIND_MEM}, check_state_t,
//   check_entry_t {final, pc, kind, index, value}.
//  Sub-module check_table: DEPTH x check_entry_t storage, 1 write port, 1 async read port, count register.
//  Top holds FSM, scan pointer, comparator, counters, fail register.
// TESTING
//  Load REG x5=42 @pc 8; retire pc 8 with probe_data 42 -> pass_count 1, fail_count 0, retire_ready low 2 cycles.
//  Same with probe_data 41 -> fail_valid pulse, fail_pc 8, expected 42, actual 41, fail_count 1.
//  Four entries @pc 12 (REG, REG, MEM idx 33, PC next 16) all correct -> pass_count 4, stall 5 cycles.
//  Fill DEPTH entries, extra load -> load_ready 0, count stays DEPTH; entry DEPTH+1 never checked.
//  Assert retire_valid and final_req together -> SCAN first, then FSCAN; done=1, retire_ready=0 thereafter.
//  Reset asserted mid-SCAN -> IDLE next cycle, counters 0, no fail_valid; count saturation via 2^CNT_W fails -> stays all-ones.

Source files
------------

// File: rtl/runtime_check_unit_pkg.sv
// Shared types for the runtime expectation checker: entry layout, check kinds and FSM states.
// Entry field widths here must match the XLEN/ADDR_W/IDX_W parameters of the users.
package risc_v_check_pkg;

    localparam int CHK_XLEN   = 32;
    localparam int CHK_ADDR_W = 32;
    localparam int CHK_IDX_W  = 6;

    typedef enum logic [1:0] {
        KIND_REG = 2'd0,
        KIND_PC  = 2'd1,
        KIND_MEM = 2'd2
    } check_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SCAN,
        ST_FSCAN,
        ST_DONE
    } check_state_t;

    // 'final' is a keyword, hence is_final
    typedef struct packed {
        logic                  is_final;
        logic [CHK_ADDR_W-1:0] pc;
        check_kind_t           kind;
        logic [CHK_IDX_W-1:0]  index;
        logic [CHK_XLEN-1:0]   value;
    } check_entry_t;

    function automatic logic kind_storable(input logic [1:0] kind);
        return kind != 2'd3;
    endfunction

endpackage

// File: rtl/runtime_check_unit_check_table.sv
// Append-only expectation table: one write port at the fill level, one async read port.
// Contents are not reset; count alone decides which entries are live.
module check_table
    import risc_v_check_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  check_entry_t wr_entry,
    input  logic [CW-1:0] rd_idx,
    output check_entry_t rd_entry,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    check_entry_t  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;

    assign wr_ok = wr_en && (count_q < DEPTH_C);

    always_comb begin
        count_d = count_q;
        if (wr_ok) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem_q[count_q[AW-1:0]] <= wr_entry;
    end

    always_comb begin
        rd_entry = '0;
        if (rd_idx < DEPTH_C) rd_entry = mem_q[rd_idx[AW-1:0]];
    end

    assign count = count_q;

endmodule

// File: rtl/runtime_check_unit.sv
// Expectation checker beside the CPU: stalls retire, walks the table one entry per cycle
// and compares matching entries against live state read through the probe port.
module runtime_check_unit
    import risc_v_check_pkg::*;
#(
    parameter int XLEN   = CHK_XLEN,
    parameter int ADDR_W = CHK_ADDR_W,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = CHK_IDX_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_final,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [1:0]        load_kind,
    input  logic [IDX_W-1:0]  load_index,
    input  logic [XLEN-1:0]   load_value,
    input  logic              retire_valid,
    output logic              retire_ready,
    input  logic [ADDR_W-1:0] retire_pc,
    input  logic [ADDR_W-1:0] retire_next_pc,
    input  logic              final_req,
    output logic [1:0]        probe_kind,
    output logic [IDX_W-1:0]  probe_index,
    input  logic [XLEN-1:0]   probe_data,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_pc,
    output logic [XLEN-1:0]   fail_expected,
    output logic [XLEN-1:0]   fail_actual,
    output logic              done
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    check_state_t      state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d, count;
    logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_cnt_q, fail_cnt_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_pc_q, fail_pc_d;
    logic [XLEN-1:0]   fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
    check_entry_t      wr_entry, rd_entry;
    logic              wr_en, scanning, last, hit;
    logic [XLEN-1:0]   actual;

    assign load_ready = (state_q == ST_IDLE) && (count < DEPTH_C);
    assign wr_en      = load_valid && load_ready && kind_storable(load_kind);

    always_comb begin
        wr_entry.is_final = load_final;
        wr_entry.pc       = load_final ? '0 : load_pc;
        wr_entry.kind     = check_kind_t'(load_kind);
        wr_entry.index    = load_index;
        wr_entry.value    = load_value;
    end

    check_table #(.DEPTH(DEPTH), .CW(CW)) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .rd_idx   (ptr_q),
        .rd_entry (rd_entry),
        .count    (count)
    );

    // The pointer runs one step past the last entry; that spare cycle closes the scan.
    assign scanning = (state_q == ST_SCAN) || (state_q == ST_FSCAN);
    assign last     = (ptr_q == count);
    assign hit      = scanning && !last &&
                      ((state_q == ST_FSCAN) ? rd_entry.is_final
                                             : (!rd_entry.is_final && rd_entry.pc == pc_q));
    assign actual   = (rd_entry.kind == KIND_PC) ? XLEN'(npc_q) : probe_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            pass_q       <= '0;
            fail_cnt_q   <= '0;
            fail_valid_q <= 1'b0;
            fail_pc_q    <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pass_q       <= pass_d;
            fail_cnt_q   <= fail_cnt_d;
            fail_valid_q <= fail_valid_d;
            fail_pc_q    <= fail_pc_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    always_ff @(posedge clock) begin
        pc_q  <= pc_d;
        npc_q <= npc_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (retire_valid) state_d = ST_SCAN;
                      else if (final_req) state_d = ST_FSCAN;
            ST_SCAN:  if (last) state_d = ST_RUN;
            ST_FSCAN: if (last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d        = (scanning && !last) ? ptr_q + 1'b1 : '0;
        pc_d         = pc_q;
        npc_d        = npc_q;
        pass_d       = pass_q;
        fail_cnt_d   = fail_cnt_q;
        fail_valid_d = 1'b0;
        fail_pc_d    = fail_pc_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;
        if (state_q == ST_RUN && retire_valid) begin
            pc_d  = retire_pc;
            npc_d = retire_next_pc;
        end
        if (hit) begin
            if (actual == rd_entry.value) begin
                pass_d = sat_inc(pass_q);
            end else begin
                fail_cnt_d   = sat_inc(fail_cnt_q);
                fail_valid_d = 1'b1;
                fail_pc_d    = rd_entry.pc;
                fail_exp_d   = rd_entry.value;
                fail_act_d   = actual;
            end
        end
    end

    always_comb begin
        retire_ready  = (state_q == ST_RUN);
        done          = (state_q == ST_DONE);
        probe_kind    = '0;
        probe_index   = '0;
        if (hit && rd_entry.kind != KIND_PC) begin
            probe_kind  = rd_entry.kind;
            probe_index = rd_entry.index;
        end
        pass_count    = pass_q;
        fail_count    = fail_cnt_q;
        fail_valid    = fail_valid_q;
        fail_pc       = fail_pc_q;
        fail_expected = fail_exp_q;
        fail_actual   = fail_act_q;
    end

endmodule

// File: tb/tb_runtime_check_unit.sv
// Bench for runtime_check_unit: directed scenarios, a table-level model of expected
// pass/fail outcomes, and a per-cycle monitor of fail pulses and load_ready.
module tb_runtime_check_unit;
    localparam int XLEN = 32, ADDR_W = 32, DEPTH = 8, IDX_W = 6, CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock, reset, start, load_valid, load_ready, load_final;
    logic [ADDR_W-1:0] load_pc, retire_pc, retire_next_pc, fail_pc;
    logic [1:0]        load_kind, probe_kind;
    logic [IDX_W-1:0]  load_index, probe_index;
    logic [XLEN-1:0]   load_value, probe_data, fail_expected, fail_actual;
    logic              retire_valid, retire_ready, final_req, fail_valid, done;
    logic [CNT_W-1:0]  pass_count, fail_count;

    runtime_check_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_final(load_final),
        .load_pc(load_pc), .load_kind(load_kind), .load_index(load_index), .load_value(load_value),
        .retire_valid(retire_valid), .retire_ready(retire_ready),
        .retire_pc(retire_pc), .retire_next_pc(retire_next_pc), .final_req(final_req),
        .probe_kind(probe_kind), .probe_index(probe_index), .probe_data(probe_data),
        .pass_count(pass_count), .fail_count(fail_count), .fail_valid(fail_valid),
        .fail_pc(fail_pc), .fail_expected(fail_expected), .fail_actual(fail_actual), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CPU architectural state seen through the probe port
    logic [XLEN-1:0] regs [64];
    logic [XLEN-1:0] mem  [64];
    always_comb begin
        probe_data = '0;
        if (probe_kind == 2'd0)      probe_data = regs[probe_index];
        else if (probe_kind == 2'd2) probe_data = mem[probe_index];
    end

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   e;
        logic [XLEN-1:0]   a;
    } fail_rec_t;

    int                n_checks = 0, n_errors = 0;
    int                m_count, exp_pass, exp_fail;
    bit                m_idle, armed = 0, ign = 0;
    bit                t_final [DEPTH];
    logic [ADDR_W-1:0] t_pc    [DEPTH];
    logic [1:0]        t_kind  [DEPTH];
    logic [IDX_W-1:0]  t_idx   [DEPTH];
    logic [XLEN-1:0]   t_val   [DEPTH];
    logic [ADDR_W-1:0] m_npc;
    fail_rec_t         fq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] cpu_state(input logic [1:0] kind, input logic [IDX_W-1:0] idx);
        if (kind == 2'd1) return m_npc;
        if (kind == 2'd0) return regs[idx];
        return mem[idx];
    endfunction

    // Expected outcome of one scan over the whole table, in load order.
    task automatic model_scan(input bit fin, input logic [ADDR_W-1:0] pc);
        logic [XLEN-1:0] act;
        for (int i = 0; i < m_count; i++) begin
            if (fin ? t_final[i] : (!t_final[i] && t_pc[i] == pc)) begin
                act = cpu_state(t_kind[i], t_idx[i]);
                if (act == t_val[i]) begin
                    if (exp_pass < CNT_MAX) exp_pass++;
                end else begin
                    if (exp_fail < CNT_MAX) exp_fail++;
                    fq.push_back('{fin ? '0 : pc, t_val[i], act});
                end
            end
        end
    endtask

    // Per-cycle monitor
    always @(negedge clock) begin
        if (armed) begin
            chk("load_ready", load_ready, (m_idle && m_count < DEPTH));
            if (!ign && fail_valid === 1'b1) begin
                if (fq.size() == 0) begin
                    chk("unexpected_fail_valid", fail_valid, 0);
                end else begin
                    chk("fail_pc", fail_pc, fq[0].pc);
                    chk("fail_expected", fail_expected, fq[0].e);
                    chk("fail_actual", fail_actual, fq[0].a);
                    void'(fq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; start = 0; load_valid = 0; retire_valid = 0; final_req = 0;
        tick();
        m_idle = 1; m_count = 0; exp_pass = 0; exp_fail = 0; fq.delete(); ign = 0; armed = 1;
        chk("rst_retire_ready", retire_ready, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_fail_valid", fail_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_probe", {probe_kind, probe_index}, 0);
        chk("rst_fail_regs", {fail_pc, fail_expected, fail_actual} == '0, 1);
        reset = 0;
    endtask

    task automatic load(input bit fin, input logic [ADDR_W-1:0] pc, input logic [1:0] kind,
                        input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] val);
        load_valid = 1; load_final = fin; load_pc = pc; load_kind = kind; load_index = idx; load_value = val;
        tick();
        load_valid = 0;
        if (m_idle && m_count < DEPTH && kind != 2'd3) begin
            t_final[m_count] = fin; t_pc[m_count] = fin ? '0 : pc; t_kind[m_count] = kind;
            t_idx[m_count] = idx; t_val[m_count] = val;
            m_count++;
        end
    endtask

    task automatic start_run();
        start = 1;
        tick();
        start = 0;
        m_idle = 0;
    endtask

    task automatic retire(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] npc, output int stall);
        int n = 0;
        chk("retire_ready_run", retire_ready, 1);
        m_npc = npc;
        model_scan(0, pc);
        retire_valid = 1; retire_pc = pc; retire_next_pc = npc;
        tick();
        retire_valid = 0;
        while (!retire_ready && n < 100) begin
            n++;
            tick();
        end
        stall = n;
        chk("retire_stall", n, m_count + 1);
        chk("pass_count", pass_count, exp_pass);
        chk("fail_count", fail_count, exp_fail);
        chk("fail_pulses_seen", fq.size(), 0);
    endtask

    task automatic final_scan(output int stall);
        int n = 0;
        final_req = 1;
        model_scan(1, '0);
        tick();
        while (!done && n < 100) begin
            n++;
            tick();
        end
        final_req = 0;
        stall = n;
        chk("final_stall", n, m_count + 1);
        chk("final_pass", pass_count, exp_pass);
        chk("final_fail", fail_count, exp_fail);
        chk("final_done", done, 1);
        chk("final_retire_ready", retire_ready, 0);
        chk("final_pulses_seen", fq.size(), 0);
    endtask

    initial begin
        int st;
        reset = 1; start = 0; load_valid = 0; load_final = 0; load_pc = '0; load_kind = '0;
        load_index = '0; load_value = '0; retire_valid = 0; retire_pc = '0; retire_next_pc = '0;
        final_req = 0;
        for (int i = 0; i < 64; i++) begin
            regs[i] = 32'h100 + i;
            mem[i]  = 32'h5000 + i;
        end
        tick();

        // Single passing REG check
        do_reset();
        regs[5] = 42;
        load(0, 8, 2'd0, 5, 42);
        start_run();
        retire(8, 12, st);
        chk("t1_stall_lit", st, 2);
        chk("t1_pass_lit", pass_count, 1);
        chk("t1_fail_lit", fail_count, 0);

        // Same check failing
        do_reset();
        regs[5] = 41;
        load(0, 8, 2'd0, 5, 42);
        start_run();
        retire(8, 12, st);
        chk("t2_fail_lit", fail_count, 1);
        chk("t2_fail_pc_lit", fail_pc, 8);
        chk("t2_exp_lit", fail_expected, 42);
        chk("t2_act_lit", fail_actual, 41);

        // Four checks at one PC, all correct
        do_reset();
        regs[1] = 11; regs[2] = 22; mem[33] = 32'hdeadbeef;
        load(0, 12, 2'd0, 1, 11);
        load(0, 12, 2'd0, 2, 22);
        load(0, 12, 2'd2, 33, 32'hdeadbeef);
        load(0, 12, 2'd1, 0, 16);
        start_run();
        retire(12, 16, st);
        chk("t3_stall_lit", st, 5);
        chk("t3_pass_lit", pass_count, 4);

        // Table overflow: ninth entry dropped and never checked
        do_reset();
        regs[1] = 77;
        for (int i = 0; i < DEPTH; i++) load(0, 100, 2'd0, 1, 77);
        chk("t4_full_lit", load_ready, 0);
        load(0, 100, 2'd0, 1, 5);
        start_run();
        retire(100, 104, st);
        chk("t4_stall_lit", st, DEPTH + 1);
        chk("t4_pass_lit", pass_count, DEPTH);
        chk("t4_fail_lit", fail_count, 0);

        // Retire and final together; reserved kind rejected; FINAL PC entry
        do_reset();
        regs[3] = 5; mem[7] = 32'h1234;
        load(0, 4, 2'd0, 3, 5);
        load(1, 0, 2'd0, 3, 5);
        load(1, 0, 2'd2, 7, 32'h9999);
        load(0, 4, 2'd3, 0, 0);
        load(1, 0, 2'd1, 0, 8);
        start_run();
        final_req = 1;
        retire(4, 8, st);
        chk("t5_scan_stall_lit", st, 5);
        chk("t5_scan_pass_lit", pass_count, 1);
        final_scan(st);
        chk("t5_fscan_stall_lit", st, 5);
        chk("t5_pass_lit", pass_count, 3);
        chk("t5_fail_lit", fail_count, 1);
        chk("t5_fail_pc_lit", fail_pc, 0);
        chk("t5_fail_exp_lit", fail_expected, 32'h9999);
        chk("t5_fail_act_lit", fail_actual, 32'h1234);
        start = 1; retire_valid = 1;
        tick(); tick();
        start = 0; retire_valid = 0;
        chk("t5_done_held", done, 1);
        chk("t5_no_retire_in_done", retire_ready, 0);
        chk("t5_pass_unchanged", pass_count, 3);

        // Fail counter saturation
        do_reset();
        regs[2] = 7;
        for (int i = 0; i < DEPTH; i++) load(0, 200, 2'd0, 2, 999);
        start_run();
        retire(200, 204, st);
        chk("t6_fail8_lit", fail_count, 8);
        retire(200, 204, st);
        chk("t6_sat_lit", fail_count, CNT_MAX);
        retire(200, 204, st);
        chk("t6_sat_hold_lit", fail_count, CNT_MAX);
        chk("t6_pass_lit", pass_count, 0);

        // Reset in the middle of a scan
        do_reset();
        regs[3] = 1;
        for (int i = 0; i < 4; i++) load(0, 300, 2'd0, 3, 2);
        start_run();
        ign = 1;
        retire_valid = 1; retire_pc = 300; retire_next_pc = 304;
        tick();
        retire_valid = 0;
        tick(); tick();
        do_reset();
        chk("t7_load_ready", load_ready, 1);
        retire_valid = 1; retire_pc = 300;
        tick(); tick(); tick();
        chk("t7_retire_ignored", retire_ready, 0);
        retire_valid = 0;
        chk("t7_fail_zero", fail_count, 0);
        chk("t7_pass_zero", pass_count, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
